// File: rtl/cic_integ_decim.sv
// cic_integ_decim: integrator-and-decimate back end of a second-order CIC.
// Two cascaded modulo-2^ACC_W accumulators run on every enabled sample.
// Every DECIM enabled samples, one scaled word is emitted with a one-cycle strobe.
// Optional build macro: CIC_DOUT_ROUND_EN selects round-half-up scaling with
// positive saturation. It only has an effect when ACC_W > OUT_W.
// Without the macro, the LSBs are truncated.
module cic_integ_decim #(
    parameter int IN_W  = 12,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int DECIM = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ACC_W-1:0]        acc1;
    logic [ACC_W-1:0]        acc2;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        din_ext;
    logic signed [OUT_W-1:0] scaled;

    // Sign-extend the incoming sample to the accumulator width.
    // When the widths are equal, the sample is used as is.
    generate
        if (ACC_W > IN_W) begin : g_sext
            assign din_ext = {{(ACC_W - IN_W){din[IN_W-1]}}, din};
        end else begin : g_nosext
            assign din_ext = din;
        end
    endgenerate

    // Output scaling: keep the top OUT_W bits of acc2.
    // These bits are either rounded or truncated, depending on the build.
    generate
        if (ACC_W == OUT_W) begin : g_full
            assign scaled = acc2;
        end else begin : g_scale
`ifdef CIC_DOUT_ROUND_EN
            localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (ACC_W - OUT_W - 1);
            localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W - 1){1'b1}}};
            logic [ACC_W:0] rnd_sum;
            logic           unused_rnd_lsbs;
            // One guard bit above the sign bit exposes a positive overflow from rounding.
            // A negative value plus half an LSB can never overflow downward.
            assign rnd_sum         = {acc2[ACC_W-1], acc2} + HALF;
            assign unused_rnd_lsbs = ^rnd_sum[ACC_W-OUT_W-1:0];
            assign scaled = (!rnd_sum[ACC_W] && rnd_sum[ACC_W-1]) ? MAX_POS
                                                                  : rnd_sum[ACC_W-1 -: OUT_W];
`else
            assign scaled = acc2[ACC_W-1 -: OUT_W];
`endif
        end
    endgenerate

    // Integrator cascade, frame counter, and output register.
    // acc2 accumulates the pre-edge value of acc1, which gives one pipeline stage between the integrators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc1       <= '0;
            acc2       <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (en) begin
                acc1 <= acc1 + din_ext;
                acc2 <= acc2 + acc1;
                if (cnt == CNT_LAST) begin
                    cnt        <= '0;
                    dout       <= scaled;
                    dout_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_integ_decim.sv
// tb_cic_integ_decim: directed checks for cic_integ_decim.
// Covered: reset state, ramp, stall, mid-frame asynchronous reset, modular wrap,
// output rounding, and a randomised run against a reference model.
// Three instances with different parameters share the clock and the reset.
module tb_cic_integ_decim;

    logic        clk = 1'b0;
    logic        reset_n;

    // Instance A: ACC_W = OUT_W = 24, DECIM = 4.
    logic        en_a;
    logic [11:0] din_a;
    logic [23:0] dout_a;
    logic        val_a;

    // Instance B: IN_W = ACC_W = OUT_W = 12, DECIM = 2.
    logic        en_b;
    logic [11:0] din_b;
    logic [11:0] dout_b;
    logic        val_b;

    // Instance C: ACC_W = 16, OUT_W = 12, DECIM = 3.
    logic        en_c;
    logic [11:0] din_c;
    logic [11:0] dout_c;
    logic        val_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cic_integ_decim #(.IN_W(12), .ACC_W(24), .OUT_W(24), .DECIM(4)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .din(din_a), .dout(dout_a), .dout_valid(val_a));
    cic_integ_decim #(.IN_W(12), .ACC_W(12), .OUT_W(12), .DECIM(2)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .din(din_b), .dout(dout_b), .dout_valid(val_b));
    cic_integ_decim #(.IN_W(12), .ACC_W(16), .OUT_W(12), .DECIM(3)) u_c (
        .clk(clk), .reset_n(reset_n), .en(en_c), .din(din_c), .dout(dout_c), .dout_valid(val_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance A, then sample 1 ns after the edge.
    task automatic cyc_a(input logic e, input logic [11:0] d);
        en_a  = e;
        din_a = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int          ramp_exp [3];
        logic [11:0] m1, m2, m_exp;
        logic        m_v;
        int          mc, nframe;
        logic [23:0] r1, r2, r_exp, r_sext;
        logic        r_v, e;
        int          rc, n_en, n_strobe, dv;
        logic [11:0] d;

        ramp_exp = '{3, 21, 55};
        reset_n = 1'b1;
        en_a = 0; din_a = '0;
        en_b = 0; din_b = '0;
        en_c = 0; din_c = '0;

        // Reset state.
        #2 reset_n = 1'b0;
        #2;
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_valid_a", 32'(val_a), 32'd0);
        chk("rst_dout_b", 32'(dout_b), 32'd0);
        chk("rst_dout_c", 32'(dout_c), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Ramp: acc2 after n edges is n(n-1)/2, so dout is 3, 21, 55 at edges 4, 8, 12.
        for (int k = 1; k <= 12; k++) begin
            cyc_a(1'b1, 12'd1);
            chk($sformatf("ramp_valid_e%0d", k), 32'(val_a), 32'(k % 4 == 0));
            if (k % 4 == 0) chk($sformatf("ramp_dout_e%0d", k), 32'(dout_a), 32'(ramp_exp[k/4-1]));
        end

        // Stall: 5 disabled cycles between enabled edges 2 and 3.
        apply_reset();
        for (int k = 1; k <= 2; k++) begin
            cyc_a(1'b1, 12'd1);
            chk("stall_pre_valid", 32'(val_a), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            cyc_a(1'b0, 12'd1);
            chk("stall_valid", 32'(val_a), 32'd0);
            chk("stall_dout", 32'(dout_a), 32'd0);
        end
        cyc_a(1'b1, 12'd1);
        chk("stall_e3_valid", 32'(val_a), 32'd0);
        cyc_a(1'b1, 12'd1);
        chk("stall_e4_valid", 32'(val_a), 32'd1);
        chk("stall_e4_dout", 32'(dout_a), 32'd3);
        for (int k = 0; k < 3; k++) begin
            cyc_a(1'b0, 12'd1);
            chk("stall_hold_valid", 32'(val_a), 32'd0);
            chk("stall_hold_dout", 32'(dout_a), 32'd3);
        end

        // Asynchronous reset mid-frame, asserted after edge 6 with no clock edge.
        apply_reset();
        for (int k = 1; k <= 6; k++) cyc_a(1'b1, 12'd1);
        chk("arst_pre_dout", 32'(dout_a), 32'd3);
        en_a = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("arst_dout", 32'(dout_a), 32'd0);
        chk("arst_valid", 32'(val_a), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc_a(1'b1, 12'd1);
            chk($sformatf("arst_post_valid_e%0d", k), 32'(val_a), 32'(k == 4));
        end
        chk("arst_post_dout", 32'(dout_a), 32'd3);
        // Reset asserted while the strobe is high must clear the strobe at once.
        en_a = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("arst_strobe_clear", 32'(val_a), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Wrap: modulo-2^12 model; hand values are 0 (acc2 after 1 edge)
        // and 3*2047 mod 4096 = 2045 (acc2 after 3 edges).
        m1 = '0; m2 = '0; mc = 0; nframe = 0;
        for (int k = 1; k <= 40; k++) begin
            en_b  = 1'b1;
            din_b = 12'h7FF;
            m_v   = (mc == 1);
            m_exp = m2;
            m2    = m2 + m1;
            m1    = m1 + din_b;
            mc    = (mc == 1) ? 0 : mc + 1;
            @(posedge clk);
            #1;
            chk("wrap_valid", 32'(val_b), 32'(m_v));
            if (m_v) begin
                nframe++;
                chk($sformatf("wrap_dout_f%0d", nframe), 32'(dout_b), 32'(m_exp));
                if (nframe == 1) chk("wrap_first", 32'(dout_b), 32'd0);
                if (nframe == 2) chk("wrap_second", 32'(dout_b), 32'd2045);
            end
        end
        en_b = 1'b0;

        // Rounding: acc2 = 8 at edge 3; 8/16 truncates to 0 and rounds to 1.
        for (int k = 1; k <= 3; k++) begin
            en_c  = 1'b1;
            din_c = 12'd8;
            @(posedge clk);
            #1;
            chk($sformatf("round_valid_e%0d", k), 32'(val_c), 32'(k == 3));
        end
        en_c = 1'b0;
`ifdef CIC_DOUT_ROUND_EN
        chk("round_dout", 32'(dout_c), 32'd1);
`else
        chk("round_dout", 32'(dout_c), 32'd0);
`endif

        // Random: 70% enable duty, din uniform in [-2,2], checked against a reference model.
        apply_reset();
        r1 = '0; r2 = '0; rc = 0; n_en = 0; n_strobe = 0;
        for (int i = 0; i < 10000; i++) begin
            e      = ($urandom_range(99) < 70);
            dv     = int'($urandom_range(4)) - 2;
            d      = 12'(dv);
            r_sext = {{12{d[11]}}, d};
            r_v    = e && (rc == 3);
            r_exp  = r2;
            if (e) begin
                n_en++;
                r2 = r2 + r1;
                r1 = r1 + r_sext;
                rc = (rc == 3) ? 0 : rc + 1;
            end
            cyc_a(e, d);
            if (val_a) n_strobe++;
            chk("rand_valid", 32'(val_a), 32'(r_v));
            if (r_v) chk("rand_dout", 32'(dout_a), 32'(r_exp));
        end
        chk("rand_strobe_count", 32'(n_strobe), 32'(n_en / 4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
